// File: rtl/hazard_sb_ctrl_pkg.sv
// Shared types for the hazard controller: exception-flush FSM states, stage bit positions, forwarding codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    EXCW  = 2'd1,
    FLUSH = 2'd2
  } excState_e;

  localparam int NSTG  = 5;
  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  // The younger producer (M) shadows W when both hold the same register.
  function automatic logic [1:0] fwdCode(input logic hitM, input logic hitW);
    if (hitM) return FWD_M;
    if (hitW) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_sb_ctrl_scoreboard.sv
// Tracks the single outstanding MDU writeback: pending GPR bit, latched dest, busy flag and timeout age.
// Latency: state updates on the clock edge; mduKill is combinational with killEn.
// Backpressure: none here; the parent blocks setEn while E is stalled.
module hazard_scoreboard #(
  parameter int REGW    = 5,
  parameter int MDU_TMO = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 setEn,
  input  logic [REGW-1:0]      setDest,
  input  logic                 doneEn,
  input  logic                 killEn,
  output logic [2**REGW-1:0]   pending,
  output logic                 busy,
  output logic                 mduKill,
  output logic                 tmo
);

  localparam int AGE_W = $clog2(MDU_TMO + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MDU_TMO);

  logic [2**REGW-1:0] pendingNext;
  logic [REGW-1:0]    destQ;
  logic [AGE_W-1:0]   age;
  logic [AGE_W-1:0]   ageNext;
  logic               busyNext;

  // Kill beats everything; a new op beats a completion in the same cycle.
  always_comb begin
    pendingNext = pending;
    busyNext    = busy;
    ageNext     = age;
    if (killEn) begin
      pendingNext = '0;
      busyNext    = 1'b0;
      ageNext     = '0;
    end else if (setEn) begin
      if (doneEn) pendingNext[destQ] = 1'b0;
      pendingNext[setDest] = 1'b1;
      busyNext             = 1'b1;
      ageNext              = '0;
    end else if (doneEn) begin
      pendingNext[destQ] = 1'b0;
      busyNext           = 1'b0;
      ageNext            = '0;
    end else if (busy && (age != AGE_MAX)) begin
      ageNext = age + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
      busy    <= 1'b0;
      age     <= '0;
      destQ   <= '0;
      tmo     <= 1'b0;
    end else begin
      pending <= pendingNext;
      busy    <= busyNext;
      age     <= ageNext;
      if (setEn && !killEn) destQ <= setDest;
      if (ageNext == AGE_MAX) tmo <= 1'b1;
    end
  end

  assign mduKill = killEn & busy;

endmodule

// File: rtl/hazard_sb_ctrl.sv
// 5-stage hazard controller: forwarding, load-use/branch/scoreboard stalls, bus-busy hold, deferred exception flush.
// Latency: stall/flush/forward are combinational; scoreboard and FSM update on the clock. Optional HAZ_PERF_CNT_EN adds stall_cnt.
// Backpressure: inst_busy/data_busy freeze the whole pipe; an exception waits in EXCW until data_busy drops.
module hazard_sb_ctrl
  import hazard_pkg::*;
#(
  parameter int REGW    = 5,
`ifdef HAZ_PERF_CNT_EN
  parameter int MDU_TMO = 64,
  parameter int CNT_W   = 16
`else
  parameter int MDU_TMO = 64
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [REGW-1:0]  rs_d,
  input  logic [REGW-1:0]  rt_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic [REGW-1:0]  rs_e,
  input  logic [REGW-1:0]  rt_e,
  input  logic [REGW-1:0]  wreg_e,
  input  logic             regwrite_e,
  input  logic             memtoreg_e,
  input  logic [REGW-1:0]  wreg_m,
  input  logic             regwrite_m,
  input  logic             memtoreg_m,
  input  logic [REGW-1:0]  wreg_w,
  input  logic             regwrite_w,
  input  logic             mdu_start_e,
  input  logic [REGW-1:0]  mdu_wreg_e,
  input  logic             mdu_done,
  input  logic             inst_busy,
  input  logic             data_busy,
  input  logic             except_m,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [NSTG-1:0]  stall,
  output logic [NSTG-1:0]  flush,
  output logic             mdu_kill,
`ifdef HAZ_PERF_CNT_EN
  output logic             mdu_tmo,
  output logic [CNT_W-1:0] stall_cnt
`else
  output logic             mdu_tmo
`endif
);

  logic [2**REGW-1:0] pending;
  logic               mduBusy;
  logic               memBusy;
  logic               lwStall;
  logic               brStall;
  logic               sbStall;
  logic               mduStall;
  logic               excFlush;
  logic               excStall;
  logic               sbSet;
  excState_e          state;
  excState_e          stateNext;

  assign fwd_a_d = (rs_d != '0) && regwrite_m && (rs_d == wreg_m);
  assign fwd_b_d = (rt_d != '0) && regwrite_m && (rt_d == wreg_m);

  assign fwd_a_e = fwdCode((rs_e != '0) && regwrite_m && (rs_e == wreg_m),
                           (rs_e != '0) && regwrite_w && (rs_e == wreg_w));
  assign fwd_b_e = fwdCode((rt_e != '0) && regwrite_m && (rt_e == wreg_m),
                           (rt_e != '0) && regwrite_w && (rt_e == wreg_w));

  assign memBusy  = inst_busy | data_busy;
  assign lwStall  = memtoreg_e && ((rt_e == rs_d) || (rt_e == rt_d));
  assign brStall  = (branch_d || jump_d) &&
                    ((regwrite_e && ((wreg_e == rs_d) || (wreg_e == rt_d))) ||
                     (memtoreg_m && ((wreg_m == rs_d) || (wreg_m == rt_d))));
  assign sbStall  = ((rs_d != '0) && pending[rs_d]) || ((rt_d != '0) && pending[rt_d]);
  assign mduStall = mdu_start_e && mduBusy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= stateNext;
  end

  // A flush cannot be issued while a data transaction is in flight, so it is parked in EXCW.
  always_comb begin
    stateNext = state;
    excFlush  = 1'b0;
    excStall  = 1'b0;
    unique case (state)
      RUN: begin
        if (except_m) begin
          if (data_busy) stateNext = EXCW;
          else           excFlush  = 1'b1;
        end
      end
      EXCW: begin
        excStall = 1'b1;
        if (!data_busy) stateNext = FLUSH;
      end
      FLUSH: begin
        excFlush  = 1'b1;
        stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  // Priority chain; a flushed stage is never also held.
  always_comb begin
    stall = '0;
    flush = '0;
    if (excFlush) begin
      flush = '1;
    end else if (excStall || memBusy) begin
      stall = '1;
    end else if (mduStall) begin
      stall[STG_F] = 1'b1;
      stall[STG_D] = 1'b1;
      stall[STG_E] = 1'b1;
      flush[STG_M] = 1'b1;
    end else if (lwStall || brStall || sbStall) begin
      stall[STG_F] = 1'b1;
      stall[STG_D] = 1'b1;
      flush[STG_E] = 1'b1;
    end
  end

  assign sbSet = mdu_start_e && !stall[STG_E] && (mdu_wreg_e != '0);

  hazard_scoreboard #(
    .REGW    (REGW),
    .MDU_TMO (MDU_TMO)
  ) u_sb (
    .clk     (clk),
    .resetn  (resetn),
    .setEn   (sbSet),
    .setDest (mdu_wreg_e),
    .doneEn  (mdu_done),
    .killEn  (excFlush),
    .pending (pending),
    .busy    (mduBusy),
    .mduKill (mdu_kill),
    .tmo     (mdu_tmo)
  );

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     stall_cnt <= '0;
    else if (|stall) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_hazard_sb_ctrl.sv
// Randomized and directed bench for hazard_sb_ctrl against a cycle-level behavioural model of the hazard rules.
module tb_hazard_sb_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w, mdu_wreg_e;
  logic       branch_d, jump_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
  logic       mdu_start_e, mdu_done, inst_busy, data_busy, except_m;
  logic       fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [4:0] stall, flush;
  logic       mdu_kill, mdu_tmo;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  localparam int M_RUN = 0, M_WAIT = 1, M_FLUSH = 2;
  bit pend[32];
  bit mBusy;
  int mDest;
  int mAge;
  bit mTmo;
  int mode;
  int stallCount;

  hazard_sb_ctrl dut (
    .clk(clk), .resetn(resetn),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .jump_d(jump_d),
    .rs_e(rs_e), .rt_e(rt_e),
    .wreg_e(wreg_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .wreg_m(wreg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .wreg_w(wreg_w), .regwrite_w(regwrite_w),
    .mdu_start_e(mdu_start_e), .mdu_wreg_e(mdu_wreg_e), .mdu_done(mdu_done),
    .inst_busy(inst_busy), .data_busy(data_busy), .except_m(except_m),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall(stall), .flush(flush), .mdu_kill(mdu_kill),
`ifdef HAZ_PERF_CNT_EN
    .mdu_tmo(mdu_tmo), .stall_cnt(stall_cnt)
`else
    .mdu_tmo(mdu_tmo)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    mBusy = 1'b0; mDest = 0; mAge = 0; mTmo = 1'b0; mode = M_RUN; stallCount = 0;
  endtask

  task automatic idleInputs();
    {rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w, mdu_wreg_e} = '0;
    {branch_d, jump_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w} = '0;
    {mdu_start_e, mdu_done, inst_busy, data_busy, except_m} = '0;
  endtask

  function automatic int fwdExp(input logic [4:0] src);
    if (src != 0 && regwrite_m && src == wreg_m) return 2;
    if (src != 0 && regwrite_w && src == wreg_w) return 1;
    return 0;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // Called at a falling edge with inputs driven; checks this cycle, advances the model, returns at the next falling edge.
  task automatic step();
    logic [4:0] eStall, eFlush;
    bit exFl, lw, br, sb;
    #2;
    exFl = (mode == M_RUN && except_m && !data_busy) || mode == M_FLUSH;
    lw   = memtoreg_e && (rt_e == rs_d || rt_e == rt_d);
    br   = (branch_d || jump_d) &&
           ((regwrite_e && (wreg_e == rs_d || wreg_e == rt_d)) ||
            (memtoreg_m && (wreg_m == rs_d || wreg_m == rt_d)));
    sb   = (rs_d != 0 && pend[rs_d]) || (rt_d != 0 && pend[rt_d]);
    if (exFl)                                           begin eStall = 5'b00000; eFlush = 5'b11111; end
    else if (mode == M_WAIT || inst_busy || data_busy)  begin eStall = 5'b11111; eFlush = 5'b00000; end
    else if (mdu_start_e && mBusy)                      begin eStall = 5'b00111; eFlush = 5'b01000; end
    else if (lw || br || sb)                            begin eStall = 5'b00011; eFlush = 5'b00100; end
    else                                                begin eStall = 5'b00000; eFlush = 5'b00000; end

    chk("fwd_a_d", 32'(fwd_a_d), 32'(rs_d != 0 && regwrite_m && rs_d == wreg_m));
    chk("fwd_b_d", 32'(fwd_b_d), 32'(rt_d != 0 && regwrite_m && rt_d == wreg_m));
    chk("fwd_a_e", 32'(fwd_a_e), fwdExp(rs_e));
    chk("fwd_b_e", 32'(fwd_b_e), fwdExp(rt_e));
    chk("stall", 32'(stall), 32'(eStall));
    chk("flush", 32'(flush), 32'(eFlush));
    chk("mdu_kill", 32'(mdu_kill), 32'(exFl && mBusy));
    chk("mdu_tmo", 32'(mdu_tmo), 32'(mTmo));
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), stallCount & 32'hFFFF);
`endif

    if (exFl) begin
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
      mBusy = 1'b0; mAge = 0;
    end else begin
      if (mdu_done) begin pend[mDest] = 1'b0; mBusy = 1'b0; mAge = 0; end
      if (mdu_start_e && !eStall[2] && mdu_wreg_e != 0) begin
        pend[mdu_wreg_e] = 1'b1; mDest = int'(mdu_wreg_e); mBusy = 1'b1; mAge = 0;
      end else if (mBusy) begin
        mAge++;
        if (mAge >= 64) mTmo = 1'b1;
      end
    end
    case (mode)
      M_RUN:   if (except_m && data_busy) mode = M_WAIT;
      M_WAIT:  if (!data_busy) mode = M_FLUSH;
      default: mode = M_RUN;
    endcase
    if (eStall != 0) stallCount++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    idleInputs();
    modelReset();
    @(negedge clk);
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_kill", 32'(mdu_kill), 0);
    chk("rst_tmo", 32'(mdu_tmo), 0);
    chk("rst_fwd", 32'({fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Forwarding priority and reg 0
    rs_e = 5'd5; wreg_m = 5'd5; regwrite_m = 1'b1; wreg_w = 5'd5; regwrite_w = 1'b1;
    #1 chk("fwd_m_pri", 32'(fwd_a_e), 2);
    step();
    rs_e = 5'd0;
    #1 chk("fwd_zero", 32'(fwd_a_e), 0);
    step();
    rs_e = 5'd5; regwrite_m = 1'b0;
    #1 chk("fwd_w", 32'(fwd_a_e), 1);
    step();
    idleInputs();

    // Load-use
    memtoreg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8;
    #1 chk("lw_stall", 32'(stall), 32'h03);
    chk("lw_flush", 32'(flush), 32'h04);
    step();
    idleInputs();
    #1 chk("lw_release", 32'(stall), 0);
    step();

    // Scoreboard hold until mdu_done
    mdu_start_e = 1'b1; mdu_wreg_e = 5'd9;
    step();
    mdu_start_e = 1'b0; mdu_wreg_e = 5'd0; rs_d = 5'd9;
    repeat (3) begin
      #1 chk("sb_hold", 32'(stall), 32'h03);
      step();
    end
    mdu_done = 1'b1;
    #1 chk("sb_hold_done", 32'(stall), 32'h03);
    step();
    mdu_done = 1'b0;
    #1 chk("sb_clear", 32'(stall), 0);
    step();
    idleInputs();

    // Exception deferred behind data_busy
    except_m = 1'b1; data_busy = 1'b1;
    #1 chk("excw_stall0", 32'(stall), 32'h1F);
    step();
    except_m = 1'b0;
    repeat (2) begin
      #1 chk("excw_stall", 32'(stall), 32'h1F);
      step();
    end
    data_busy = 1'b0;
    step();
    #1 chk("exc_flush", 32'(flush), 32'h1F);
    chk("exc_flush_nostall", 32'(stall), 0);
    step();
    #1 chk("exc_run", 32'(flush), 0);
    step();

    // Exception kills an in-flight MDU op
    mdu_start_e = 1'b1; mdu_wreg_e = 5'd12;
    step();
    mdu_start_e = 1'b0; except_m = 1'b1;
    #1 chk("kill_flush", 32'(flush), 32'h1F);
    chk("kill_pulse", 32'(mdu_kill), 1);
    step();
    except_m = 1'b0; rs_d = 5'd12;
    #1 chk("sb_killed", 32'(stall), 0);
    chk("kill_once", 32'(mdu_kill), 0);
    step();
    idleInputs();

    // Reset while parked in EXCW
    except_m = 1'b1; data_busy = 1'b1;
    step();
    except_m = 1'b0;
    step();
    resetn = 1'b0; data_busy = 1'b0;
    #2 chk("rst_excw", 32'(flush), 0);
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("excw_post_rst", 32'(flush), 0);
    step();

    // MDU timeout boundary and stickiness
    mdu_start_e = 1'b1; mdu_wreg_e = 5'd7;
    step();
    mdu_start_e = 1'b0; mdu_wreg_e = 5'd0;
    repeat (60) step();
    #1 chk("tmo_early", 32'(mdu_tmo), 0);
    repeat (6) step();
    #1 chk("tmo_set", 32'(mdu_tmo), 1);
    mdu_done = 1'b1;
    step();
    mdu_done = 1'b0;
    #1 chk("tmo_sticky", 32'(mdu_tmo), 1);
    resetn = 1'b0;
    #2 chk("tmo_rst", 32'(mdu_tmo), 0);
    modelReset();
    @(negedge clk);
    resetn = 1'b1;

    // Random traffic on a small register set so hazards collide often
    repeat (2500) begin
      rs_d = 5'($urandom_range(0, 3));  rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3));  rt_e = 5'($urandom_range(0, 3));
      wreg_e = 5'($urandom_range(0, 3)); wreg_m = 5'($urandom_range(0, 3));
      wreg_w = 5'($urandom_range(0, 3)); mdu_wreg_e = 5'($urandom_range(0, 3));
      branch_d = pct(20); jump_d = pct(10);
      regwrite_e = pct(50); memtoreg_e = pct(25);
      regwrite_m = pct(50); memtoreg_m = pct(25); regwrite_w = pct(50);
      mdu_start_e = pct(15); mdu_done = pct(15);
      inst_busy = pct(8); data_busy = pct(10); except_m = pct(4);
      step();
    end
    idleInputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
